adc_serial_emu: RTL and testbench

Cycle-accurate emulator of the front-end sigma-delta ADC serial port, clocked on weClk. It drives CLK_S_D_OUT/ADC_OUT into WETOP's ADC capture path in place of the on-chip converter. It obeys RST_ADC/SLP from WETOP and emits deterministic 16-bit sample frames (ramp, LFSR, constant, alternating), so the capture, ping-pong FIFO and PipeOut 0xA2 chain can be checked bit-exact from the host.

---
 rtl/adc_serial_emu_if.sv | 24 ++
 rtl/adc_serial_emu.sv | 173 +++++++++++++++++
 tb/tb_adc_serial_emu.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_serial_emu_if.sv
// rtl/adc_serial_emu_if.sv - WETOP control inputs and serial ADC outputs of the emulated converter
interface adc_serial_emu_if #(
    parameter int DATA_W = 16
);
    logic              rst_adc;
    logic              slp;
    logic [1:0]        pattern_sel;
    logic [DATA_W-1:0] cfg_const;
    logic              clk_s_d_out;
    logic              dout;
    logic              busy;
    logic [31:0]       frame_cnt;

    // master is the emulated converter, slave is the WETOP capture side
    modport master (
        input  rst_adc, slp, pattern_sel, cfg_const,
        output clk_s_d_out, dout, busy, frame_cnt
    );

    modport slave (
        output rst_adc, slp, pattern_sel, cfg_const,
        input  clk_s_d_out, dout, busy, frame_cnt
    );
endinterface

// File: rtl/adc_serial_emu.sv
// rtl/adc_serial_emu.sv - cycle-accurate sigma-delta ADC serial port emulator with deterministic patterns
module adc_serial_emu #(
    parameter int                DATA_W    = 16,
    parameter int                WAKE_CYC  = 8,
    parameter int                GAP_CYC   = 4,
    parameter logic [DATA_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic             weClk,
    input  logic             rst_we,
    adc_serial_emu_if.master bus
);

    localparam int WAKE_W = $clog2(WAKE_CYC + 1);
    localparam int GAP_W  = $clog2(GAP_CYC + 1);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] ALT_INIT = {(DATA_W/2){2'b10}};

    typedef enum logic [1:0] {
        ST_SLEEP = 2'd0,
        ST_WAKE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
    logic               phase_q, phase_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  ramp_q, ramp_d;
    logic [DATA_W-1:0]  lfsr_q, lfsr_d;
    logic [DATA_W-1:0]  alt_q, alt_d;
    logic [31:0]        frame_cnt_q, frame_cnt_d;
    logic               sclk_q, sclk_d;
    logic               dout_q, dout_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  gen_val;
    logic               lfsr_fb;
    logic               load;

    assign lfsr_fb = lfsr_q[DATA_W-1] ^ lfsr_q[DATA_W-3] ^ lfsr_q[DATA_W-4] ^ lfsr_q[DATA_W-6];

    always_comb begin
        gen_val = ramp_q;
        case (bus.pattern_sel)
            2'd1:    gen_val = lfsr_q;
            2'd2:    gen_val = bus.cfg_const;
            2'd3:    gen_val = alt_q;
            default: gen_val = ramp_q;
        endcase
    end

    // Outputs are computed from the next state so they change on the same edge as the state
    always_comb begin
        state_d     = state_q;
        wake_cnt_d  = wake_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        bit_idx_d   = bit_idx_q;
        phase_d     = phase_q;
        shreg_d     = shreg_q;
        ramp_d      = ramp_q;
        lfsr_d      = lfsr_q;
        alt_d       = alt_q;
        frame_cnt_d = frame_cnt_q;
        sclk_d      = 1'b0;
        dout_d      = 1'b0;
        load        = 1'b0;

        case (state_q)
            ST_SLEEP: begin
                if (!bus.slp) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                if (bus.slp)                                   state_d    = ST_SLEEP;
                else if (wake_cnt_q == WAKE_W'(WAKE_CYC))       load       = 1'b1;
                else                                           wake_cnt_d = wake_cnt_q + 1'b1;
            end
            ST_SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                    dout_d  = shreg_q[DATA_W-1];
                end else if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
                    // every generator steps on frame completion, selected or not
                    state_d     = ST_GAP;
                    gap_cnt_d   = '0;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    ramp_d      = ramp_q + 1'b1;
                    lfsr_d      = {lfsr_q[DATA_W-2:0], lfsr_fb};
                    alt_d       = ~alt_q;
                end else begin
                    phase_d   = 1'b0;
                    bit_idx_d = bit_idx_q + 1'b1;
                    shreg_d   = shreg_q << 1;
                    dout_d    = shreg_q[DATA_W-2];
                end
            end
            ST_GAP: begin
                if (bus.slp)                                   state_d   = ST_SLEEP;
                else if (gap_cnt_q == GAP_W'(GAP_CYC - 1))      load      = 1'b1;
                else                                           gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = ST_SLEEP;
        endcase

        if (load) begin
            state_d   = ST_SHIFT;
            shreg_d   = gen_val;
            bit_idx_d = '0;
            phase_d   = 1'b0;
            dout_d    = gen_val[DATA_W-1];
        end

        if (bus.rst_adc) begin
            state_d     = ST_SLEEP;
            wake_cnt_d  = '0;
            gap_cnt_d   = '0;
            bit_idx_d   = '0;
            phase_d     = 1'b0;
            shreg_d     = '0;
            ramp_d      = '0;
            lfsr_d      = LFSR_SEED;
            alt_d       = ALT_INIT;
            frame_cnt_d = '0;
            sclk_d      = 1'b0;
            dout_d      = 1'b0;
        end

        busy_d = (state_d != ST_SLEEP);
    end

    always_ff @(posedge weClk or posedge rst_we) begin
        if (rst_we) begin
            state_q     <= ST_SLEEP;
            wake_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            bit_idx_q   <= '0;
            phase_q     <= 1'b0;
            shreg_q     <= '0;
            ramp_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            alt_q       <= ALT_INIT;
            frame_cnt_q <= '0;
            sclk_q      <= 1'b0;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wake_cnt_q  <= wake_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_idx_q   <= bit_idx_d;
            phase_q     <= phase_d;
            shreg_q     <= shreg_d;
            ramp_q      <= ramp_d;
            lfsr_q      <= lfsr_d;
            alt_q       <= alt_d;
            frame_cnt_q <= frame_cnt_d;
            sclk_q      <= sclk_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.clk_s_d_out = sclk_q;
    assign bus.dout        = dout_q;
    assign bus.busy        = busy_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_adc_serial_emu.sv
// tb/tb_adc_serial_emu.sv - directed and randomized checks of adc_serial_emu against a timeline model
module tb_adc_serial_emu;

    localparam int DW     = 16;
    localparam int WAKE   = 8;
    localparam int GAP    = 4;
    localparam int LEAD   = WAKE + 1;
    localparam int PERIOD = 2 * DW + GAP;

    logic weClk = 1'b0;
    logic rst_we;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   e0      = 0;
    int   n0      = 0;

    logic [15:0] rx_q[$];
    int          rise_q[$];

    // Model: position on the wake/frame timeline plus the frames completed since reset
    bit          m_active;
    int          m_t;
    logic [31:0] m_n;
    logic [15:0] m_lfsr;
    logic [15:0] m_sample;

    adc_serial_emu_if #(.DATA_W(DW)) bus ();

    adc_serial_emu #(
        .DATA_W   (DW),
        .WAKE_CYC (WAKE),
        .GAP_CYC  (GAP),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .weClk (weClk),
        .rst_we(rst_we),
        .bus   (bus)
    );

    always #5 weClk = ~weClk;

    initial begin
        forever begin
            @(posedge weClk);
            cyc++;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL timeout %s: event not seen within cycle budget (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    initial begin
        int p;
        m_active = 0; m_t = 0; m_n = '0; m_lfsr = 16'hACE1; m_sample = '0;
        forever begin
            @(posedge weClk or posedge rst_we);
            if (rst_we || bus.rst_adc) begin
                m_active = 0; m_t = 0; m_n = '0; m_lfsr = 16'hACE1;
            end else if (!m_active) begin
                if (!bus.slp) begin
                    m_active = 1;
                    m_t = 0;
                end
            end else begin
                p = (m_t >= LEAD) ? (m_t - LEAD) % PERIOD : -1;
                if ((p < 0 || p >= 2 * DW) && bus.slp) begin
                    m_active = 0;
                end else begin
                    if (p == 2 * DW - 1) begin
                        m_n++;
                        m_lfsr = lfsr_step(m_lfsr);
                    end
                    m_t++;
                    if (m_t >= LEAD && (m_t - LEAD) % PERIOD == 0) begin
                        case (bus.pattern_sel)
                            2'd0: m_sample = m_n[15:0];
                            2'd1: m_sample = m_lfsr;
                            2'd2: m_sample = bus.cfg_const;
                            default: m_sample = m_n[0] ? 16'h5555 : 16'hAAAA;
                        endcase
                    end
                end
            end
        end
    end

    // Compare DUT against the model every cycle and deserialize what the DUT sends
    initial begin
        int          p;
        logic        es, ed, prev_sclk;
        int          bitcnt;
        logic [15:0] shw;
        prev_sclk = 1'b0; bitcnt = 0; shw = '0;
        forever begin
            @(negedge weClk);
            es = 1'b0; ed = 1'b0;
            if (m_active && m_t >= LEAD) begin
                p = (m_t - LEAD) % PERIOD;
                if (p < 2 * DW) begin
                    es = p[0];
                    ed = m_sample[DW - 1 - p / 2];
                end
            end
            check("clk_s_d_out", {31'd0, bus.clk_s_d_out}, {31'd0, es});
            check("dout",        {31'd0, bus.dout},        {31'd0, ed});
            check("busy",        {31'd0, bus.busy},        {31'd0, m_active});
            check("frame_cnt",   bus.frame_cnt,            m_n);
            if (!m_active) begin
                bitcnt = 0;
            end else if (bus.clk_s_d_out && !prev_sclk) begin
                rise_q.push_back(cyc);
                shw = {shw[14:0], bus.dout};
                bitcnt++;
                if (bitcnt == DW) begin
                    rx_q.push_back(shw);
                    bitcnt = 0;
                end
            end
            prev_sclk = bus.clk_s_d_out;
        end
    end

    task automatic step();
        @(negedge weClk);
        #1;
    endtask

    task automatic wait_rx(input int n, input string nm);
        int b = 0;
        while (rx_q.size() < n && b < 2000) begin
            step();
            b++;
        end
        if (rx_q.size() < n) timeout_fail(nm);
    endtask

    task automatic wait_rise(input int n, input string nm);
        int b = 0;
        while (rise_q.size() < n && b < 2000) begin
            step();
            b++;
        end
        if (rise_q.size() < n) timeout_fail(nm);
    endtask

    task automatic adc_reset();
        step();
        bus.rst_adc = 1'b1;
        step();
        bus.rst_adc = 1'b0;
        rx_q.delete();
        rise_q.delete();
        e0 = cyc + 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst_we = 1'b1;
        bus.rst_adc = 1'b0;
        bus.slp = 1'b0;
        bus.pattern_sel = 2'd0;
        bus.cfg_const = '0;
        repeat (3) step();
        check("rst clk_s_d_out", {31'd0, bus.clk_s_d_out}, 32'd0);
        check("rst dout",        {31'd0, bus.dout},        32'd0);
        check("rst busy",        {31'd0, bus.busy},        32'd0);
        check("rst frame_cnt",   bus.frame_cnt,            32'd0);
        rst_we = 1'b0;
        e0 = cyc + 1;
        rx_q.delete();
        rise_q.delete();

        // ramp after reset release
        wait_rx(4, "ramp frames");
        check("first rise latency", rise_q[0] - e0, 32'd10);
        for (int k = 0; k < 4; k++) check("ramp word", {16'd0, rx_q[k]}, k);
        check("in-frame rise spacing", rise_q[1] - rise_q[0], 32'd2);
        check("frame spacing 0-1", rise_q[16] - rise_q[0], 32'd36);
        check("frame spacing 2-3", rise_q[48] - rise_q[32], 32'd36);
        step();
        check("ramp frame_cnt", bus.frame_cnt, 32'd4);

        // constant, then alternating selected mid-frame
        bus.pattern_sel = 2'd2;
        bus.cfg_const = 16'hBEEF;
        adc_reset();
        wait_rise(2 * DW + 3, "const mid-frame");
        bus.pattern_sel = 2'd3;
        bus.cfg_const = 16'h1234;
        wait_rx(5, "alt frames");
        check("const 0", {16'd0, rx_q[0]}, 32'hBEEF);
        check("const 1", {16'd0, rx_q[1]}, 32'hBEEF);
        check("const kept mid-frame", {16'd0, rx_q[2]}, 32'hBEEF);
        check("alt after 3 frames", {16'd0, rx_q[3]}, 32'h5555);
        check("alt after 4 frames", {16'd0, rx_q[4]}, 32'hAAAA);

        // LFSR
        bus.pattern_sel = 2'd1;
        adc_reset();
        wait_rx(3, "lfsr frames");
        check("lfsr 0", {16'd0, rx_q[0]}, 32'hACE1);
        check("lfsr 1", {16'd0, rx_q[1]}, 32'h59C3);
        check("lfsr 2", {16'd0, rx_q[2]}, 32'hB387);

        // sleep requested during frame 0x0002
        bus.pattern_sel = 2'd0;
        adc_reset();
        wait_rise(2 * DW + 5, "sleep bit 5");
        bus.slp = 1'b1;
        wait_rx(3, "sleep frame");
        check("frame finished under slp", {16'd0, rx_q[2]}, 32'h0002);
        repeat (3) step();
        check("sleep busy", {31'd0, bus.busy}, 32'd0);
        check("sleep frame_cnt", bus.frame_cnt, 32'd3);
        repeat (5) step();
        bus.slp = 1'b0;
        e0 = cyc + 1;
        n0 = rise_q.size();
        wait_rx(4, "wake frame");
        check("frame after wake", {16'd0, rx_q[3]}, 32'h0003);
        check("wake rise latency", rise_q[n0] - e0, 32'd10);

        // rst_adc during the bit-9 high phase of the next frame
        n0 = rise_q.size();
        wait_rise(n0 + 10, "bit 9 high");
        bus.rst_adc = 1'b1;
        step();
        check("rst_adc clk_s_d_out", {31'd0, bus.clk_s_d_out}, 32'd0);
        check("rst_adc dout",        {31'd0, bus.dout},        32'd0);
        check("rst_adc frame_cnt",   bus.frame_cnt,            32'd0);
        bus.rst_adc = 1'b0;
        rx_q.delete();
        rise_q.delete();
        wait_rx(1, "post rst_adc frame");
        check("ramp restart", {16'd0, rx_q[0]}, 32'h0000);

        // randomized traffic, checked cycle by cycle against the model
        bus.slp = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (bus.rst_adc) bus.rst_adc = 1'b0;
            if (rst_we) rst_we = 1'b0;
            if ($urandom_range(149) == 0) bus.slp = ~bus.slp;
            if ($urandom_range(39) == 0) bus.pattern_sel = 2'($urandom_range(3));
            if ($urandom_range(39) == 0) bus.cfg_const = 16'($urandom);
            if ($urandom_range(699) == 0) bus.rst_adc = 1'b1;
            if ($urandom_range(1499) == 0) rst_we = 1'b1;
        end
        bus.rst_adc = 1'b0;
        rst_we = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
